// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its upstream issue queue.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } issue_state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request handshake plus the narrow ALU operand bus.
interface alu_issue_queue_if #(
    parameter int W = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [1:0]   req_op;
    logic [W-1:0] alu_in;
    logic [1:0]   alu_op;
    logic         alu_valid;
    logic         alu_ready;

    // master is the sequencer; slave is the producer plus ALU
    modport master (
        input  req_valid, req_a, req_b, req_op, alu_ready,
        output req_ready, alu_in, alu_op, alu_valid
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, alu_ready,
        input  req_ready, alu_in, alu_op, alu_valid
    );
endinterface

// File: rtl/req_fifo.sv
// Small synchronous FIFO with count-based full/empty.
module req_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests and serialises them onto the ALU operand bus.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_issue_queue_if.master      bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    issue_state_t  state;
    issue_state_t  state_n;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_n;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    req_t          head;
    req_t          wreq;
    logic [W-1:0]  in_n;
    logic [1:0]    op_n;
    logic          valid_n;
    logic          to_n;

    assign wreq = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
    assign push = bus.req_valid && !full;
    assign bus.req_ready = !full;
    assign busy = state != IDLE;

    req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wreq),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (level)
    );

    // outputs are computed for the state being entered, then registered
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        pop     = 1'b0;
        to_n    = 1'b0;
        valid_n = 1'b0;
        in_n    = '0;
        op_n    = '0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = ISSUE;
                    valid_n = 1'b1;
                    in_n    = head.a;
                    op_n    = head.op;
                end
            end
            ISSUE: begin
                state_n = WAIT;
                wcnt_n  = '0;
                in_n    = head.b;
                op_n    = head.op;
            end
            WAIT: begin
                if (bus.alu_ready) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end else if (wcnt == WLAST) begin
                    pop     = 1'b1;
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                    in_n   = head.b;
                    op_n   = head.op;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            timeout       <= 1'b0;
            bus.alu_valid <= 1'b0;
            bus.alu_in    <= '0;
            bus.alu_op    <= '0;
        end else begin
            state         <= state_n;
            wcnt          <= wcnt_n;
            timeout       <= to_n;
            bus.alu_valid <= valid_n;
            bus.alu_in    <= in_n;
            bus.alu_op    <= op_n;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed and randomized checks of alu_issue_queue against a queue model.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       timeout;
    logic [1:0] level;

    alu_issue_queue_if #(.W(W)) bus ();

    alu_issue_queue #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .level   (level),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // model: pending requests, phase 0/1/2 = idle/issue/wait,
    // and WAIT cycles already spent on the head
    alu_req_t   mq[$];
    int         mph = 0;
    int         mw  = 0;
    logic       mv  = 1'b0;
    logic       mto = 1'b0;
    logic [7:0] min = '0;
    logic [1:0] mop = '0;
    logic [7:0] seen[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(bit v, logic [7:0] a, logic [7:0] b, logic [1:0] op);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
    endtask

    task automatic model_step();
        bit acc;
        if (rst) begin
            mq.delete();
            mph = 0; mw = 0; mv = 0; min = 0; mop = 0; mto = 0;
            return;
        end
        acc = bus.req_valid && (mq.size() < DEPTH);
        mto = 0; mv = 0; min = 0; mop = 0;
        if (mph == 0) begin
            if (mq.size() > 0) begin
                mph = 1; mv = 1; min = mq[0].a; mop = mq[0].op;
            end
        end else if (mph == 1) begin
            mph = 2; mw = 0; min = mq[0].b; mop = mq[0].op;
        end else if (bus.alu_ready || mw == TO - 1) begin
            mto = !bus.alu_ready;
            void'(mq.pop_front());
            mph = 0;
        end else begin
            mw++; min = mq[0].b; mop = mq[0].op;
        end
        if (acc)
            mq.push_back('{op: bus.req_op, a: bus.req_a, b: bus.req_b});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.alu_valid === 1'b1)
            seen.push_back(bus.alu_in);
        chk("req_ready", bus.req_ready, mq.size() < DEPTH);
        chk("busy", busy, mph != 0);
        chk("level", level, mq.size());
        chk("alu_valid", bus.alu_valid, mv);
        chk("alu_in", bus.alu_in, min);
        chk("alu_op", bus.alu_op, mop);
        chk("timeout", timeout, mto);
    endtask

    initial begin
        bus.alu_ready = 1'b0;
        drive(1, 8'hAA, 8'hBB, 2'd1);

        // reset held with a request offered
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_valid", bus.alu_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);

        // single request, completion on last allowed WAIT cycle
        cyc = 0;
        drive(1, 8'h05, 8'h03, 2'b10);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("t2_valid", bus.alu_valid, 1);
        chk("t2_a", bus.alu_in, 8'h05);
        chk("t2_op", bus.alu_op, 2'b10);
        for (int i = 3; i <= 9; i++) begin
            tick();
            chk("t2_b", bus.alu_in, 8'h03);
        end
        tick();
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("t2_cyc", cyc, 11);
        chk("t2_busy", busy, 0);
        chk("t2_level", level, 0);
        chk("t2_timeout", timeout, 0);

        // backpressure and ordering
        seen.delete();
        cyc = 0;
        drive(1, 8'h01, 8'h11, 2'd1);
        tick();
        drive(1, 8'h02, 8'h12, 2'd2);
        tick();
        chk("t3_full_lvl", level, 2);
        chk("t3_full_rdy", bus.req_ready, 0);
        drive(1, 8'h03, 8'h13, 2'd3);
        tick();
        tick();
        tick();
        chk("t3_stall_rdy", bus.req_ready, 0);
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("t3_rdy_back", bus.req_ready, 1);
        chk("t3_lvl1", level, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("t3_lvl2", level, 2);
        chk("t3_iss2", bus.alu_in, 8'h02);
        chk("t3_iss2_v", bus.alu_valid, 1);
        tick();
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        tick();
        chk("t3_iss3", bus.alu_in, 8'h03);
        tick();
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("t3_seen_n", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk("t3_order", seen[i], i + 1);

        // watchdog drop, then ready during ISSUE and on WAIT cycle 8
        cyc = 0;
        drive(1, 8'h11, 8'h91, 2'd3);
        tick();
        drive(1, 8'h22, 8'h92, 2'd1);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 3; i <= 12; i++) begin
            tick();
            chk("t4_timeout", timeout, cyc == 11);
        end
        chk("t4_issue_v", bus.alu_valid, 1);
        chk("t4_issue_a", bus.alu_in, 8'h22);
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("t5_wait_busy", busy, 1);
        chk("t5_wait_v", bus.alu_valid, 0);
        chk("t5_wait_b", bus.alu_in, 8'h92);
        while (cyc < 20)
            tick();
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("t5_no_to", timeout, 0);
        chk("t5_idle", busy, 0);
        chk("t5_level", level, 0);

        // reset in WAIT with two queued
        cyc = 0;
        drive(1, 8'h33, 8'h43, 2'd0);
        tick();
        drive(1, 8'h44, 8'h54, 2'd2);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("t6_pre_lvl", level, 2);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", bus.alu_valid, 0);
        chk("t6_timeout", timeout, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t6_no_to", timeout, 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 3) != 0, 8'($urandom), 8'($urandom),
                  2'($urandom));
            bus.alu_ready = ($urandom % 7) == 0;
            rst = ($urandom % 250) == 0;
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
